// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a W-bit add/subtract through one external 4-bit adder slice, LS nibble first.
// Ports: Clk/Reset (sync, active-high); Run, Sub, A_in, B_in start an operation in IDLE;
// slice_A/slice_B/slice_cin drive the slice, slice_S/slice_cout return from it;
// Busy (ADD state), Done (one-cycle result pulse), Sum/C_out/Overflow hold the result.
// Optional macro NIBBLE_SERIAL_SATURATE_EN saturates Sum on signed overflow.
module nibble_serial_adder #(
  parameter int NIBBLES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Sub,
  input  logic [4*NIBBLES-1:0] A_in,
  input  logic [4*NIBBLES-1:0] B_in,
  output logic [3:0]           slice_A,
  output logic [3:0]           slice_B,
  output logic                 slice_cin,
  input  logic [3:0]           slice_S,
  input  logic                 slice_cout,
  output logic                 Busy,
  output logic                 Done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 C_out,
  output logic                 Overflow
);
  localparam int W = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_opa, r_opb, r_sum;
  logic [IW-1:0] r_idx;
  logic r_carry, r_cout, r_ovf;
  logic w_last, w_ovf, w_add;
  assign w_add = r_state == ADD;
  assign w_last = r_idx == LAST;
  // Only the top slice's sum bit matters: overflow when like-signed operands give an opposite-signed result.
  assign w_ovf = (r_opa[W-1] == r_opb[W-1]) && (slice_S[3] != r_opa[W-1]);
  assign Sum = r_sum;
  assign C_out = r_cout;
  assign Overflow = r_ovf;
  always_ff @(posedge Clk)
    r_state <= Reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (Run ? ADD : IDLE) :
             r_state == ADD  ? (w_last ? DONE : ADD) : IDLE;
    Busy = w_add;
    Done = r_state == DONE;
    slice_A = w_add ? r_opa[4*r_idx +: 4] : 4'h0;
    slice_B = w_add ? r_opb[4*r_idx +: 4] : 4'h0;
    slice_cin = w_add & r_carry;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_opa <= '0;
      r_opb <= '0;
      r_sum <= '0;
      r_idx <= '0;
      r_carry <= 1'b0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && Run) begin
      // Subtract as A + ~B + 1: the +1 enters as the first carry-in.
      r_opa <= A_in;
      r_opb <= Sub ? ~B_in : B_in;
      r_carry <= Sub;
      r_idx <= '0;
      r_sum <= '0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_add) begin
      r_sum[4*r_idx +: 4] <= slice_S;
      r_carry <= slice_cout;
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= slice_cout;
        r_ovf <= w_ovf;
`ifdef NIBBLE_SERIAL_SATURATE_EN
        if (w_ovf)
          r_sum <= r_opa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      end
    end
  end
endmodule
